lane_aligned_deserializer: RTL and testbench
============================================

Name: lane_aligned_deserializer

Overview:
Multi-lane serial-to-parallel converter with per-lane sync-word alignment, for the USB4 logical-layer receive path. Each lane hunts for a SYNC_PATTERN boundary, then deserialises DATA_WIDTH-bit words. It merges one word from every lane into a single LANES*DATA_WIDTH word and presents it on a valid/ready interface with back-pressure and overflow reporting. It sits between the lane PHY bit outputs and the receive framing logic.

Parameters:
DATA_WIDTH, 8, bits per lane word (>=2)
LANES, 2, number of serial lanes (>=1)
MSB_FIRST, 1, 1: first received bit lands in word bit DATA_WIDTH-1; 0: first received bit lands in bit 0
SYNC_PATTERN, 8'hBC, DATA_WIDTH-bit alignment word, compared in final word orientation

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
enable  input  1  deserialisation enable, shared by all lanes
serial_in  input  LANES  one serial bit per lane per enabled cycle
out_data  output  LANES*DATA_WIDTH  merged word; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  out_data holds an unaccepted word
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
lane_locked  output  LANES  per-lane LOCKED indication
overflow  output  1  sticky: a lane word was lost
clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0): all lanes go to HUNT. Shift windows, bit counters, hold registers and hold_valid flags clear. out_data=0, out_valid=0, lane_locked=0, overflow=0.
- Per lane, each enabled cycle: window_next = window shifted by one, with serial_in[i] inserted.
  - MSB_FIRST=1: shift left, new bit in bit 0.
  - MSB_FIRST=0: shift right, new bit in bit DATA_WIDTH-1.
- Lane FSM, HUNT:
  - If window_next == SYNC_PATTERN, go to LOCKED with bit counter=0 on that edge.
  - Otherwise stay in HUNT. No words are produced.
- Lane FSM, LOCKED:
  - Counter increments each enabled cycle.
  - When counter == DATA_WIDTH-1, the word is complete: word = window_next and counter wraps to 0.
  - A completed word equal to SYNC_PATTERN is a realignment marker. It is discarded and the lane stays LOCKED.
  - Any other completed word is written to the lane hold register and hold_valid[i] is set.
- lane_locked[i] = 1 exactly when lane i is in LOCKED.
- enable=0 for one or more cycles:
  - All lanes return to HUNT; windows, counters, holds and hold_valid clear.
  - out_data, out_valid and overflow are retained, and a pending output can still be accepted.
- Merge: on an edge where all hold_valid=1 and (out_valid=0 or out_ready=1):
  - out_data is loaded with the concatenation of the holds, and out_valid=1.
  - All hold_valid clear. A lane word completing on that same edge refills its hold with no loss.
- Acceptance without merge: out_valid && out_ready with no merge that edge clears out_valid; out_data keeps its value.
- Latency: a word whose last bit on the last-completing lane is sampled at edge N is held at N. It appears on out_data/out_valid after edge N+1, earliest.
- Overflow:
  - A lane completes a non-sync word while hold_valid[i]=1 and no merge occurs that edge: the new word is dropped and the old hold is kept.
  - overflow is set on that edge.
  - clear_ovf=1 clears overflow. If a clear and a new loss occur on the same edge, set wins.
- out_data must not change while out_valid=1 and out_ready=0.
- Lanes align independently. A lane that locks late simply delays the merge; skew above one word per lane is reported only via overflow.

Test Plan:
1. Reset + lock, with DATA_WIDTH=8, LANES=2, MSB_FIRST=1 (default bit orientation).
   - Stimulus: stream random bits, then 0xBC on both lanes, then 0x12 on lane0 and 0x34 on lane1, out_ready=1.
   - Required: lane_locked=2'b11 after the 0xBC last bit; out_data=16'h3412 and out_valid=1 for one cycle, one cycle after the last data bit.
2. LSB-first mode (MSB_FIRST=0).
   - Stimulus: SYNC sent LSB first, then 0xA5 on both lanes.
   - Required: out_data=16'hA5A5.
3. Back-pressure.
   - Stimulus: out_ready=0 while three word pairs 0x01/0x02, 0x03/0x04, 0x05/0x06 arrive.
   - Required: out_data holds 16'h0201 stably; the second pair sits in the holds; the third pair sets overflow=1 and is dropped.
   - Then raise out_ready: 16'h0201 followed by 16'h0403; clear_ovf returns overflow to 0.
4. Embedded sync and skew.
   - Stimulus: lane1 sends 0xBC mid-stream; lane0 locks 3 bits later than lane1.
   - Required: the 0xBC word is not output; merged words still pair correctly, e.g. 0x11/0x22 gives 16'h2211.
5. Enable drop mid-word.
   - Stimulus: deassert enable for 1 cycle after 4 bits of a word, with out_valid=1 pending.
   - Required: lane_locked=0; the pending out_data is still accepted; the partial word is never output.
   - Lanes must re-hunt and lock again on the next 0xBC.
6. Asynchronous reset mid-word.
   - Stimulus: pulse rst low between clock edges while out_valid=1.
   - Required: out_valid, lane_locked and overflow go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lane_aligned_deserializer_if.sv
// Receive-side bus of the lane-aligned deserializer: serial lane inputs,
// merged valid/ready output and lane status.
interface lane_aligned_deserializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2
);
  logic                        enable;
  logic [LANES-1:0]            serial_in;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0]            lane_locked;
  logic                        overflow;
  logic                        clear_ovf;

  modport master (
    output enable, serial_in, out_ready, clear_ovf,
    input  out_data, out_valid, lane_locked, overflow
  );

  modport slave (
    input  enable, serial_in, out_ready, clear_ovf,
    output out_data, out_valid, lane_locked, overflow
  );
endinterface

// File: rtl/lane_aligned_deserializer.sv
// Multi-lane deserializer: each lane hunts for the sync word, assembles words,
// and one word per lane is merged onto a valid/ready output with sticky overflow.
module lane_aligned_deserializer #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LANES        = 2,
  parameter bit                    MSB_FIRST    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = 8'hBC
) (
  input logic                        clk,
  input logic                        rst,
  lane_aligned_deserializer_if.slave bus
);
  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic            HUNT     = 1'b0;
  localparam logic            LOCKED   = 1'b1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [LANES-1:0]                 state_q, state_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] win_q, win_d, win_next_s;
  logic [LANES-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic [LANES-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [LANES-1:0]                 hv_q, hv_d, done_s;
  logic [LANES*DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic                             out_valid_q, out_valid_d;
  logic                             ovf_q, ovf_d;
  logic                             merge_s, lost_s;

  // Shift window including this cycle's bit, in final word orientation
  always_comb begin
    win_next_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (MSB_FIRST) begin
        win_next_s[i] = {win_q[i][DATA_WIDTH-2:0], bus.serial_in[i]};
      end else begin
        win_next_s[i] = {bus.serial_in[i], win_q[i][DATA_WIDTH-1:1]};
      end
    end
  end

  // Lane FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= {LANES{HUNT}};
    end else begin
      state_q <= state_d;
    end
  end

  // Lane FSM next state: dropping enable sends every lane back to hunting
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < LANES; i++) begin
      if (!bus.enable) begin
        state_d[i] = HUNT;
      end else begin
        case (state_q[i])
          HUNT: begin
            if (win_next_s[i] == SYNC_PATTERN) begin
              state_d[i] = LOCKED;
            end else begin
              state_d[i] = HUNT;
            end
          end
          LOCKED:  state_d[i] = LOCKED;
          default: state_d[i] = HUNT;
        endcase
      end
    end
  end

  // Lane FSM outputs: window/counter update and word-complete strobes
  always_comb begin
    win_d  = win_q;
    cnt_d  = cnt_q;
    done_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!bus.enable) begin
        win_d[i] = '0;
        cnt_d[i] = '0;
      end else begin
        win_d[i] = win_next_s[i];
        if (state_q[i] == LOCKED) begin
          if (cnt_q[i] == LAST_BIT) begin
            cnt_d[i]  = '0;
            // an in-stream sync word only realigns; it never reaches the holds
            done_s[i] = (win_next_s[i] != SYNC_PATTERN);
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Hold registers, merge onto the output and overflow tracking
  always_comb begin
    merge_s     = bus.enable && (&hv_q) && (!out_valid_q || bus.out_ready);
    hold_d      = hold_q;
    hv_d        = hv_q;
    lost_s      = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (!bus.enable) begin
      hold_d = '0;
      hv_d   = '0;
    end else begin
      if (merge_s) begin
        hv_d = '0;
      end else begin
        hv_d = hv_q;
      end
      // a merge frees the hold on this edge, so a word completing now refills it
      for (int i = 0; i < LANES; i++) begin
        if (done_s[i]) begin
          if (merge_s || !hv_q[i]) begin
            hold_d[i] = win_next_s[i];
            hv_d[i]   = 1'b1;
          end else begin
            lost_s = 1'b1;
          end
        end else begin
          hold_d[i] = hold_q[i];
        end
      end
    end
    if (merge_s) begin
      out_data_d  = hold_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (lost_s) begin
      ovf_d = 1'b1;
    end else if (bus.clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hv_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hv_q        <= hv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.lane_locked = state_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_lane_aligned_deserializer.sv
// Scoreboard bench: an MSB-first and an LSB-first instance receive the same
// logical word streams; a bit-history reference model predicts merged words.
module tb_lane_aligned_deserializer;
  localparam int           W    = 8;
  localparam int           L    = 2;
  localparam logic [W-1:0] SYNC = 8'hBC;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         en   = 1'b0;
  logic         rdy  = 1'b0;
  logic         clr  = 1'b0;
  logic [L-1:0] ser0 = '0;
  logic [L-1:0] ser1 = '0;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  lane_aligned_deserializer_if #(.DATA_WIDTH(W), .LANES(L)) bus0 ();
  lane_aligned_deserializer_if #(.DATA_WIDTH(W), .LANES(L)) bus1 ();

  assign bus0.enable    = en;
  assign bus0.serial_in = ser0;
  assign bus0.out_ready = rdy;
  assign bus0.clear_ovf = clr;
  assign bus1.enable    = en;
  assign bus1.serial_in = ser1;
  assign bus1.out_ready = rdy;
  assign bus1.clear_ovf = clr;

  lane_aligned_deserializer #(.DATA_WIDTH(W), .LANES(L), .MSB_FIRST(1'b1), .SYNC_PATTERN(SYNC))
    u_msb (.clk(clk), .rst(rst), .bus(bus0));
  lane_aligned_deserializer #(.DATA_WIDTH(W), .LANES(L), .MSB_FIRST(1'b0), .SYNC_PATTERN(SYNC))
    u_lsb (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: k=0 MSB-first instance, k=1 LSB-first instance
  bit             m_lock[2][L];
  bit             m_hist[2][L][W];   // index 0 = oldest received bit
  int             m_nb[2][L];
  bit   [W-1:0]   m_hold[2][L];
  bit             m_hv[2][L];
  bit             m_ov[2];
  bit             m_ovf[2];
  logic [L*W-1:0] exp_q0[$], exp_q1[$], acc0[$], acc1[$];
  bit   [1:0]     sq0[$], sq1[$];    // per lane: {msb-instance bit, lsb-instance bit}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [W-1:0] assemble(input int k, input int i);
    bit [W-1:0] w;
    for (int j = 0; j < W; j++) begin
      if (k == 0) w[W-1-j] = m_hist[k][i][j];
      else        w[j]     = m_hist[k][i][j];
    end
    return w;
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < L; i++) begin
      m_lock[k][i] = 1'b0; m_nb[k][i] = 0; m_hold[k][i] = '0; m_hv[k][i] = 1'b0;
      for (int j = 0; j < W; j++) m_hist[k][i][j] = 1'b0;
    end
    m_ov[k] = 1'b0; m_ovf[k] = 1'b0;
    if (k == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  task automatic model_edge(input int k);
    logic [L-1:0] s;
    bit   [W-1:0] wd[L];
    bit           done[L];
    bit           merge, lost;
    logic [L*W-1:0] o;
    s = (k == 0) ? ser0 : ser1;
    if (!en) begin
      for (int i = 0; i < L; i++) begin
        m_lock[k][i] = 1'b0; m_nb[k][i] = 0; m_hold[k][i] = '0; m_hv[k][i] = 1'b0;
        for (int j = 0; j < W; j++) m_hist[k][i][j] = 1'b0;
      end
      if (m_ov[k] && rdy) m_ov[k] = 1'b0;
      if (clr) m_ovf[k] = 1'b0;
      return;
    end
    merge = 1'b1;
    for (int i = 0; i < L; i++) merge = merge & m_hv[k][i];
    merge = merge && (!m_ov[k] || rdy);
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < W - 1; j++) m_hist[k][i][j] = m_hist[k][i][j+1];
      m_hist[k][i][W-1] = s[i];
      wd[i] = assemble(k, i);
      done[i] = 1'b0;
      if (!m_lock[k][i]) begin
        if (wd[i] == SYNC) begin m_lock[k][i] = 1'b1; m_nb[k][i] = 0; end
      end else begin
        m_nb[k][i]++;
        if (m_nb[k][i] == W) begin
          m_nb[k][i] = 0;
          done[i] = (wd[i] != SYNC);
        end
      end
    end
    if (merge) begin
      o = '0;
      for (int i = 0; i < L; i++) begin
        o[i*W +: W] = m_hold[k][i];
        m_hv[k][i] = 1'b0;
      end
      if (k == 0) exp_q0.push_back(o); else exp_q1.push_back(o);
      m_ov[k] = 1'b1;
    end else if (m_ov[k] && rdy) begin
      m_ov[k] = 1'b0;
    end
    lost = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (done[i]) begin
        if (!m_hv[k][i]) begin m_hold[k][i] = wd[i]; m_hv[k][i] = 1'b1; end
        else lost = 1'b1;
      end
    end
    if (lost) m_ovf[k] = 1'b1;
    else if (clr) m_ovf[k] = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      model_edge(0);
      model_edge(1);
    end
  end

  task automatic mon(input int k);
    logic [L*W-1:0] d;
    logic           v, of;
    logic [L-1:0]   lk, elk;
    if (k == 0) begin d = bus0.out_data; v = bus0.out_valid; lk = bus0.lane_locked; of = bus0.overflow; end
    else        begin d = bus1.out_data; v = bus1.out_valid; lk = bus1.lane_locked; of = bus1.overflow; end
    for (int i = 0; i < L; i++) elk[i] = m_lock[k][i];
    chk($sformatf("lane_locked[inst%0d]", k), 32'(lk), 32'(elk));
    chk($sformatf("overflow[inst%0d]", k), 32'(of), 32'(m_ovf[k]));
    chk($sformatf("out_valid[inst%0d]", k), 32'(v), 32'(m_ov[k]));
    if (v) begin
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        checks++; failures++;
        $display("FAIL unexpected_word[inst%0d]: got %h, expected no word", k, d);
      end else if (k == 0) begin
        chk("out_data[inst0]", 32'(d), 32'(exp_q0[0]));
        if (rdy) begin void'(exp_q0.pop_front()); acc0.push_back(d); end
      end else begin
        chk("out_data[inst1]", 32'(d), 32'(exp_q1[0]));
        if (rdy) begin void'(exp_q1.pop_front()); acc1.push_back(d); end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon(0);
      mon(1);
    end
  end

  function automatic bit in_q(input logic [L*W-1:0] q[$], input logic [L*W-1:0] v);
    foreach (q[n]) if (q[n] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [L*W-1:0] back(input logic [L*W-1:0] q[$], input int off);
    if (q.size() <= off) return 'x;
    return q[q.size()-1-off];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input int lane, input logic [W-1:0] w);
    for (int t = 0; t < W; t++) begin
      if (lane == 0) sq0.push_back({w[W-1-t], w[t]});
      else           sq1.push_back({w[W-1-t], w[t]});
    end
  endtask

  task automatic push_rand(input int lane, input int n);
    bit b;
    for (int t = 0; t < n; t++) begin
      b = 1'($urandom);
      if (lane == 0) sq0.push_back({b, b}); else sq1.push_back({b, b});
    end
  endtask

  task automatic play(input bit rnd);
    bit [1:0] b0, b1;
    while (sq0.size() > 0 || sq1.size() > 0) begin
      b0 = (sq0.size() > 0) ? sq0.pop_front() : 2'b00;
      b1 = (sq1.size() > 0) ? sq1.pop_front() : 2'b00;
      ser0 = {b1[1], b0[1]};
      ser1 = {b1[0], b0[0]};
      if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 15) == 0);
        en  = ($urandom_range(0, 49) != 0);
      end
      cyc();
    end
    ser0 = '0;
    ser1 = '0;
  endtask

  task automatic both(input string nm, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] e);
    chk({nm, "[inst0]"}, a0, e);
    chk({nm, "[inst1]"}, a1, e);
  endtask

  initial begin
    int nw;
    repeat (3) cyc();
    both("reset_out_data", 32'(bus0.out_data), 32'(bus1.out_data), 32'h0);
    both("reset_out_valid", 32'(bus0.out_valid), 32'(bus1.out_valid), 32'h0);
    both("reset_lane_locked", 32'(bus0.lane_locked), 32'(bus1.lane_locked), 32'h0);
    both("reset_overflow", 32'(bus0.overflow), 32'(bus1.overflow), 32'h0);
    rst = 1'b1;
    cyc();

    // lock after a short random prefix, then data words in both orientations
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < L; i++) begin push_rand(i, 5); push_word(i, SYNC); end
    push_word(0, 8'h12); push_word(1, 8'h34);
    push_word(0, 8'hA5); push_word(1, 8'hA5);
    play(1'b0);
    repeat (3) cyc();
    both("word_3412", 32'(in_q(acc0, 16'h3412)), 32'(in_q(acc1, 16'h3412)), 32'h1);
    both("word_a5a5", 32'(in_q(acc0, 16'hA5A5)), 32'(in_q(acc1, 16'hA5A5)), 32'h1);

    // back-pressure and overflow
    en = 1'b0; cyc(); en = 1'b1; rdy = 1'b0;
    for (int i = 0; i < L; i++) push_word(i, SYNC);
    push_word(0, 8'h01); push_word(1, 8'h02);
    push_word(0, 8'h03); push_word(1, 8'h04);
    push_word(0, 8'h05); push_word(1, 8'h06);
    play(1'b0);
    both("bp_out_data", 32'(bus0.out_data), 32'(bus1.out_data), 32'h0201);
    both("bp_out_valid", 32'(bus0.out_valid), 32'(bus1.out_valid), 32'h1);
    both("bp_overflow", 32'(bus0.overflow), 32'(bus1.overflow), 32'h1);
    rdy = 1'b1;
    cyc(); cyc();
    both("bp_first", 32'(back(acc0, 1)), 32'(back(acc1, 1)), 32'h0201);
    both("bp_second", 32'(back(acc0, 0)), 32'(back(acc1, 0)), 32'h0403);
    clr = 1'b1; cyc(); clr = 1'b0; cyc();
    both("ovf_cleared", 32'(bus0.overflow), 32'(bus1.overflow), 32'h0);

    // lane0 locks 3 bits after lane1; both carry an in-stream sync word
    en = 1'b0; cyc(); en = 1'b1;
    push_rand(0, 3);
    push_word(0, SYNC); push_word(0, 8'h11); push_word(0, SYNC); push_word(0, 8'h33);
    push_word(1, SYNC); push_word(1, 8'h22); push_word(1, SYNC); push_word(1, 8'h44);
    play(1'b0);
    repeat (4) cyc();
    both("skew_2211", 32'(in_q(acc0, 16'h2211)), 32'(in_q(acc1, 16'h2211)), 32'h1);
    both("skew_4433", 32'(in_q(acc0, 16'h4433)), 32'(in_q(acc1, 16'h4433)), 32'h1);

    // enable drop mid-word with an output pending
    en = 1'b0; cyc(); en = 1'b1; rdy = 1'b0;
    push_word(0, SYNC); push_word(1, SYNC);
    push_word(0, 8'h5A); push_word(1, 8'hC3);
    push_rand(0, 4); push_rand(1, 4);
    play(1'b0);
    en = 1'b0; cyc();
    both("drop_lane_locked", 32'(bus0.lane_locked), 32'(bus1.lane_locked), 32'h0);
    both("drop_out_valid", 32'(bus0.out_valid), 32'(bus1.out_valid), 32'h1);
    both("drop_out_data", 32'(bus0.out_data), 32'(bus1.out_data), 32'hC35A);
    en = 1'b1; rdy = 1'b1; cyc();
    both("drop_accepted", 32'(back(acc0, 0)), 32'(back(acc1, 0)), 32'hC35A);
    push_word(0, SYNC); push_word(1, SYNC);
    push_word(0, 8'h77); push_word(1, 8'h88);
    play(1'b0);
    repeat (3) cyc();
    both("relock_8877", 32'(back(acc0, 0)), 32'(back(acc1, 0)), 32'h8877);

    // asynchronous reset between edges with output pending and overflow set
    en = 1'b0; cyc(); en = 1'b1; rdy = 1'b0;
    for (int i = 0; i < L; i++) push_word(i, SYNC);
    push_word(0, 8'h99); push_word(1, 8'hAA);
    push_word(0, 8'h11); push_word(1, 8'h22);
    push_word(0, 8'h33); push_word(1, 8'h44);
    play(1'b0);
    cyc();
    both("pre_rst_out_valid", 32'(bus0.out_valid), 32'(bus1.out_valid), 32'h1);
    both("pre_rst_overflow", 32'(bus0.overflow), 32'(bus1.overflow), 32'h1);
    #1 rst = 1'b0;
    #1;
    both("arst_out_valid", 32'(bus0.out_valid), 32'(bus1.out_valid), 32'h0);
    both("arst_lane_locked", 32'(bus0.lane_locked), 32'(bus1.lane_locked), 32'h0);
    both("arst_overflow", 32'(bus0.overflow), 32'(bus1.overflow), 32'h0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    #1 rst = 1'b1;
    cyc();

    // randomized traffic: skew, in-stream syncs, back-pressure, clears, enable drops
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < L; i++) begin
        push_rand(i, $urandom_range(0, 4));
        push_word(i, SYNC);
        nw = $urandom_range(1, 4);
        for (int n = 0; n < nw; n++) begin
          if ($urandom_range(0, 7) == 0) push_word(i, SYNC);
          else push_word(i, 8'($urandom));
        end
      end
      play(1'b1);
    end

    // drain: every predicted word must have been presented and accepted
    en = 1'b0; rdy = 1'b1; clr = 1'b0;
    repeat (4) cyc();
    chk("drain_inst0", 32'(exp_q0.size()), 32'h0);
    chk("drain_inst1", 32'(exp_q1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
